// File: rtl/io_periph_if.sv
// Load/store bus between the core's LSU and the memory-mapped I/O block.
// The master drives address, store data and strobes; the slave returns read data and hit.
interface io_periph_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    logic        wren;
    logic [31:0] rdata;
    logic        hit;

    modport master (
        output addr,
        output wdata,
        output bmask,
        output wren,
        input  rdata,
        input  hit
    );

    modport slave (
        input  addr,
        input  wdata,
        input  bmask,
        input  wren,
        output rdata,
        output hit
    );
endinterface

// File: rtl/io_periph.sv
// Memory-mapped I/O peripheral: LED and seven-segment registers plus a
// synchronised, debounced switch register, decoded on 4 KiB pages.
module io_periph #(
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter logic [31:0] HEX_RESET       = 32'h7F7F_7F7F
) (
    input  logic        i_clk,
    input  logic        i_reset,
    io_periph_if.slave  bus,
    input  logic [31:0] i_io_sw,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [6:0]  o_io_hex0,
    output logic [6:0]  o_io_hex1,
    output logic [6:0]  o_io_hex2,
    output logic [6:0]  o_io_hex3,
    output logic [6:0]  o_io_hex4,
    output logic [6:0]  o_io_hex5,
    output logic [6:0]  o_io_hex6,
    output logic [6:0]  o_io_hex7
);

    localparam logic [19:0] PAGE_LEDR  = 20'h10000;
    localparam logic [19:0] PAGE_LEDG  = 20'h10001;
    localparam logic [19:0] PAGE_HEXLO = 20'h10002;
    localparam logic [19:0] PAGE_HEXHI = 20'h10003;
    localparam logic [19:0] PAGE_SW    = 20'h10010;

    localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [31:0] ledr_q;
    logic [31:0] ledg_q;
    logic [31:0] hexlo_q;
    logic [31:0] hexhi_q;

    logic [31:0]      sync1_q;
    logic [31:0]      sync2_q;
    logic [31:0]      cand_q;
    logic [31:0]      sw_stable_q;
    logic [CNT_W-1:0] cnt_q;

    logic [19:0] page;
    logic        sel_ledr;
    logic        sel_ledg;
    logic        sel_hexlo;
    logic        sel_hexhi;
    logic        sel_sw;

    // Offset within the page is deliberately ignored so registers alias.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.addr[11:0];

    assign page      = bus.addr[31:12];
    assign sel_ledr  = (page == PAGE_LEDR);
    assign sel_ledg  = (page == PAGE_LEDG);
    assign sel_hexlo = (page == PAGE_HEXLO);
    assign sel_hexhi = (page == PAGE_HEXHI);
    assign sel_sw    = (page == PAGE_SW);

    assign bus.hit = sel_ledr | sel_ledg | sel_hexlo | sel_hexhi | sel_sw;

    always_comb begin
        bus.rdata = 32'h0;
        if (sel_ledr)  bus.rdata = ledr_q;
        if (sel_ledg)  bus.rdata = ledg_q;
        if (sel_hexlo) bus.rdata = hexlo_q;
        if (sel_hexhi) bus.rdata = hexhi_q;
        if (sel_sw)    bus.rdata = sw_stable_q;
    end

    // Byte-masked stores; the SW page and unmapped pages select nothing here.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ledr_q  <= 32'h0;
            ledg_q  <= 32'h0;
            hexlo_q <= HEX_RESET;
            hexhi_q <= HEX_RESET;
        end else if (bus.wren) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.bmask[k]) begin
                    if (sel_ledr)  ledr_q[8*k +: 8]  <= bus.wdata[8*k +: 8];
                    if (sel_ledg)  ledg_q[8*k +: 8]  <= bus.wdata[8*k +: 8];
                    if (sel_hexlo) hexlo_q[8*k +: 8] <= bus.wdata[8*k +: 8];
                    if (sel_hexhi) hexhi_q[8*k +: 8] <= bus.wdata[8*k +: 8];
                end
            end
        end
    end

    // Two-flop synchroniser followed by a saturating stability counter.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync1_q     <= 32'h0;
            sync2_q     <= 32'h0;
            cand_q      <= 32'h0;
            sw_stable_q <= 32'h0;
            cnt_q       <= '0;
        end else begin
            sync1_q <= i_io_sw;
            sync2_q <= sync1_q;
            if (sync2_q != cand_q) begin
                cand_q <= sync2_q;
                cnt_q  <= '0;
            end else if (cnt_q == CNT_MAX) begin
                sw_stable_q <= cand_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign o_io_ledr = ledr_q;
    assign o_io_ledg = ledg_q;
    assign o_io_hex0 = hexlo_q[6:0];
    assign o_io_hex1 = hexlo_q[14:8];
    assign o_io_hex2 = hexlo_q[22:16];
    assign o_io_hex3 = hexlo_q[30:24];
    assign o_io_hex4 = hexhi_q[6:0];
    assign o_io_hex5 = hexhi_q[14:8];
    assign o_io_hex6 = hexhi_q[22:16];
    assign o_io_hex7 = hexhi_q[30:24];

endmodule
